// File: rtl/sh2_load_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : sh2_load_writeback_if
// Description : Signal bundle for the SH-2 writeback stage. The slave modport
//               is the writeback block; the master modport is its environment
//               (execute/decode/bus on the input side, register file on the
//               output side).
//               Inputs : ce, ex_* (port A result), ld_* (load issue),
//                        bus_ack/bus_d (load data), *_chk/chk_en (decode).
//               Outputs: wa_*/wae (port A), wb_*/wbe (port B),
//                        hazard, ld_busy, ld_err.
// Revision    : 1.0 - initial release
// ============================================================================
interface sh2_load_writeback_if;
    logic        ce_i;
    logic        ex_we_i;
    logic [4:0]  ex_addr_i;
    logic [31:0] ex_d_i;
    logic        ld_req_i;
    logic [4:0]  ld_addr_i;
    logic [1:0]  ld_size_i;
    logic        ld_signed_i;
    logic [1:0]  ld_offs_i;
    logic        bus_ack_i;
    logic [31:0] bus_d_i;
    logic [4:0]  ra_chk_i;
    logic [4:0]  rb_chk_i;
    logic [4:0]  dst_chk_i;
    logic [2:0]  chk_en_i;
    logic [4:0]  wa_addr_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wa_d_o;
    logic [31:0] wb_d_o;
    logic        wae_o;
    logic        wbe_o;
    logic        hazard_o;
    logic        ld_busy_o;
    logic        ld_err_o;

    modport slave (
        input  ce_i, ex_we_i, ex_addr_i, ex_d_i,
        input  ld_req_i, ld_addr_i, ld_size_i, ld_signed_i, ld_offs_i,
        input  bus_ack_i, bus_d_i,
        input  ra_chk_i, rb_chk_i, dst_chk_i, chk_en_i,
        output wa_addr_o, wb_addr_o, wa_d_o, wb_d_o, wae_o, wbe_o,
        output hazard_o, ld_busy_o, ld_err_o
    );

    modport master (
        output ce_i, ex_we_i, ex_addr_i, ex_d_i,
        output ld_req_i, ld_addr_i, ld_size_i, ld_signed_i, ld_offs_i,
        output bus_ack_i, bus_d_i,
        output ra_chk_i, rb_chk_i, dst_chk_i, chk_en_i,
        input  wa_addr_o, wb_addr_o, wa_d_o, wb_d_o, wae_o, wbe_o,
        input  hazard_o, ld_busy_o, ld_err_o
    );
endinterface
`default_nettype wire

// File: rtl/sh2_load_writeback.sv
`default_nettype none
// ============================================================================
// Module      : sh2_load_writeback
// Description : SH-2 writeback stage. Port A registers execute results on CE.
//               Port B retires a single outstanding load: captures bus data,
//               extracts/extends it big-endian and holds the write until a CE
//               cycle. A per-register pending scoreboard drives the decode
//               stall (hazard).
//               Ports: clk_i, rst_n_i (async active-low), bus (slave modport
//               of sh2_load_writeback_if).
// Revision    : 1.0 - initial release
// ============================================================================
module sh2_load_writeback #(
    parameter int REG_NUM = 17          // must be <= 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_n_i,
    sh2_load_writeback_if.slave   bus
);

    localparam logic [5:0] REG_LIM = 6'(REG_NUM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          dst_q, dst_d;
    logic [1:0]          size_q, size_d;
    logic                sign_q, sign_d;
    logic [1:0]          offs_q, offs_d;
    logic [REG_NUM-1:0]  pend_q, pend_d;
    logic [4:0]          wb_addr_q, wb_addr_d;
    logic [31:0]         wb_d_q, wb_d_d;
    logic                wbe_q, wbe_d;
    logic                err_q, err_d;
    logic [4:0]          wa_addr_q;
    logic [31:0]         wa_d_q;
    logic                wae_q;

    logic                w_ld_valid, w_ex_valid, w_retire, w_busy, w_accept;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_ext;

    // Scoreboard lookup; addresses outside the register range never hit.
    function automatic logic pend_hit(input logic [4:0] a, input logic [REG_NUM-1:0] p);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < REG_NUM; k++) begin
            if (a == 5'(k)) hit = p[k];
        end
        return hit;
    endfunction

    assign w_ld_valid = ({1'b0, bus.ld_addr_i} < REG_LIM);
    assign w_ex_valid = ({1'b0, bus.ex_addr_i} < REG_LIM);
    // The retire cycle frees the slot, allowing a back-to-back request.
    assign w_retire   = (state_q == S_READY) && bus.ce_i;
    assign w_busy     = (state_q != S_IDLE) && !w_retire;
    assign w_accept   = bus.ce_i && bus.ld_req_i && !w_busy && w_ld_valid;

    // Big-endian lane selection: offset 0 is the most significant byte.
    always_comb begin
        w_byte = 8'h00;
        case (offs_q)
            2'd0:    w_byte = bus.bus_d_i[31:24];
            2'd1:    w_byte = bus.bus_d_i[23:16];
            2'd2:    w_byte = bus.bus_d_i[15:8];
            default: w_byte = bus.bus_d_i[7:0];
        endcase
        w_half = offs_q[1] ? bus.bus_d_i[15:0] : bus.bus_d_i[31:16];
        w_ext  = bus.bus_d_i;
        case (size_q)
            2'd0:    w_ext = sign_q ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            2'd1:    w_ext = sign_q ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            default: w_ext = bus.bus_d_i;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        size_d    = size_q;
        sign_d    = sign_q;
        offs_d    = offs_q;
        pend_d    = pend_q;
        wb_addr_d = wb_addr_q;
        wb_d_d    = wb_d_q;
        wbe_d     = wbe_q;
        err_d     = err_q | (bus.ce_i & bus.ld_req_i & w_busy);

        case (state_q)
            S_WAIT: begin
                if (bus.bus_ack_i) begin
                    wb_d_d    = w_ext;
                    wb_addr_d = dst_q;
                    wbe_d     = 1'b1;
                    state_d   = S_READY;
                end
            end
            S_READY: begin
                if (bus.ce_i) begin
                    wbe_d   = 1'b0;
                    state_d = S_IDLE;
                    for (int k = 0; k < REG_NUM; k++) begin
                        if (dst_q == 5'(k)) pend_d[k] = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        // Set after the retire clear so a back-to-back load to the same
        // register keeps its pending bit.
        if (w_accept) begin
            dst_d   = bus.ld_addr_i;
            size_d  = bus.ld_size_i;
            sign_d  = bus.ld_signed_i;
            offs_d  = bus.ld_offs_i;
            state_d = S_WAIT;
            for (int k = 0; k < REG_NUM; k++) begin
                if (bus.ld_addr_i == 5'(k)) pend_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            dst_q     <= 5'd0;
            size_q    <= 2'd0;
            sign_q    <= 1'b0;
            offs_q    <= 2'd0;
            pend_q    <= '0;
            wb_addr_q <= 5'd0;
            wb_d_q    <= 32'h0;
            wbe_q     <= 1'b0;
            err_q     <= 1'b0;
            wa_addr_q <= 5'd0;
            wa_d_q    <= 32'h0;
            wae_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dst_q     <= dst_d;
            size_q    <= size_d;
            sign_q    <= sign_d;
            offs_q    <= offs_d;
            pend_q    <= pend_d;
            wb_addr_q <= wb_addr_d;
            wb_d_q    <= wb_d_d;
            wbe_q     <= wbe_d;
            err_q     <= err_d;
            if (bus.ce_i) begin
                wa_addr_q <= bus.ex_addr_i;
                wa_d_q    <= bus.ex_d_i;
                wae_q     <= bus.ex_we_i & w_ex_valid;
            end
        end
    end

    assign bus.wa_addr_o = wa_addr_q;
    assign bus.wa_d_o    = wa_d_q;
    assign bus.wae_o     = wae_q;
    assign bus.wb_addr_o = wb_addr_q;
    assign bus.wb_d_o    = wb_d_q;
    assign bus.wbe_o     = wbe_q;
    assign bus.ld_busy_o = w_busy;
    assign bus.ld_err_o  = err_q;
    assign bus.hazard_o  = (bus.chk_en_i[0] & pend_hit(bus.ra_chk_i,  pend_q))
                         | (bus.chk_en_i[1] & pend_hit(bus.rb_chk_i,  pend_q))
                         | (bus.chk_en_i[2] & pend_hit(bus.dst_chk_i, pend_q));

endmodule
`default_nettype wire

// File: tb/tb_sh2_load_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_sh2_load_writeback
// Description : Directed self-checking bench for sh2_load_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sh2_load_writeback;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sh2_load_writeback_if bus ();

    sh2_load_writeback #(.REG_NUM(17)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] a, input logic [1:0] sz, input logic sg, input logic [1:0] of);
        bus.ce_i        = 1'b1;
        bus.ld_req_i    = 1'b1;
        bus.ld_addr_i   = a;
        bus.ld_size_i   = sz;
        bus.ld_signed_i = sg;
        bus.ld_offs_i   = of;
        step();
        bus.ld_req_i    = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        bus.bus_ack_i = 1'b1;
        bus.bus_d_i   = d;
        step();
        bus.bus_ack_i = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.ce_i        = 1'b0;
        bus.ex_we_i     = 1'b0;
        bus.ex_addr_i   = 5'd0;
        bus.ex_d_i      = 32'h0;
        bus.ld_req_i    = 1'b0;
        bus.ld_addr_i   = 5'd0;
        bus.ld_size_i   = 2'd0;
        bus.ld_signed_i = 1'b0;
        bus.ld_offs_i   = 2'd0;
        bus.bus_ack_i   = 1'b0;
        bus.bus_d_i     = 32'h0;
        bus.ra_chk_i    = 5'd0;
        bus.rb_chk_i    = 5'd0;
        bus.dst_chk_i   = 5'd0;
        bus.chk_en_i    = 3'b000;
        step();
        step();

        // Reset state
        check("rst_wae",    bus.wae_o,     32'd0);
        check("rst_wbe",    bus.wbe_o,     32'd0);
        check("rst_wb_d",   bus.wb_d_o,    32'd0);
        check("rst_busy",   bus.ld_busy_o, 32'd0);
        check("rst_err",    bus.ld_err_o,  32'd0);
        check("rst_hazard", bus.hazard_o,  32'd0);
        rst_n = 1'b1;
        step();

        // Port A execute write
        bus.ce_i      = 1'b1;
        bus.ex_we_i   = 1'b1;
        bus.ex_addr_i = 5'd5;
        bus.ex_d_i    = 32'hDEADBEEF;
        step();
        check("exA_wae",  bus.wae_o,     32'd1);
        check("exA_addr", bus.wa_addr_o, 32'd5);
        check("exA_d",    bus.wa_d_o,    32'hDEADBEEF);
        bus.ex_addr_i = 5'd20;           // out of range: discarded
        step();
        check("exA_oor_wae", bus.wae_o, 32'd0);
        bus.ex_we_i = 1'b0;

        // Byte, signed, offset 2
        bus.ra_chk_i = 5'd3;
        bus.chk_en_i = 3'b001;
        issue(5'd3, 2'd0, 1'b1, 2'd2);
        check("lb_busy",   bus.ld_busy_o, 32'd1);
        check("lb_hazard", bus.hazard_o,  32'd1);
        ack(32'h1122F344);
        check("lbs_wbe",  bus.wbe_o,     32'd1);
        check("lbs_d",    bus.wb_d_o,    32'hFFFFFFF3);
        check("lbs_addr", bus.wb_addr_o, 32'd3);
        check("lbs_busy_retire", bus.ld_busy_o, 32'd0);
        step();
        check("lbs_wbe_off",   bus.wbe_o,    32'd0);
        check("lbs_hazard_off", bus.hazard_o, 32'd0);

        // Byte, unsigned, offset 2
        issue(5'd3, 2'd0, 1'b0, 2'd2);
        ack(32'h1122F344);
        check("lbu_d", bus.wb_d_o, 32'h000000F3);
        step();

        // Byte, unsigned, offset 3
        issue(5'd1, 2'd0, 1'b0, 2'd3);
        ack(32'h000000FF);
        check("lbu3_d", bus.wb_d_o, 32'h000000FF);
        step();

        // Word, unsigned, offset 1 (low offset bit ignored: upper half)
        issue(5'd1, 2'd1, 1'b0, 2'd1);
        ack(32'hBEEF0000);
        check("lwu1_d", bus.wb_d_o, 32'h0000BEEF);
        step();

        // Word, signed, offset 2, held with CE=0
        bus.ra_chk_i = 5'd7;
        issue(5'd7, 2'd1, 1'b1, 2'd2);
        bus.ce_i = 1'b0;
        ack(32'h12348001);
        check("lws_d",    bus.wb_d_o,    32'hFFFF8001);
        check("lws_addr", bus.wb_addr_o, 32'd7);
        for (int i = 0; i < 4; i++) begin
            step();
            check("lws_hold_wbe",    bus.wbe_o,     32'd1);
            check("lws_hold_hazard", bus.hazard_o,  32'd1);
            check("lws_hold_busy",   bus.ld_busy_o, 32'd1);
        end
        bus.ce_i = 1'b1;
        step();
        check("lws_rel_wbe",    bus.wbe_o,    32'd0);
        check("lws_rel_hazard", bus.hazard_o, 32'd0);

        // Back-to-back to the same register in the retire cycle
        bus.ra_chk_i = 5'd2;
        issue(5'd2, 2'd2, 1'b0, 2'd0);
        ack(32'hCAFE0001);
        check("b2b_first_d", bus.wb_d_o, 32'hCAFE0001);
        issue(5'd2, 2'd2, 1'b0, 2'd0);
        check("b2b_wbe",    bus.wbe_o,     32'd0);
        check("b2b_busy",   bus.ld_busy_o, 32'd1);
        check("b2b_hazard", bus.hazard_o,  32'd1);
        check("b2b_err",    bus.ld_err_o,  32'd0);
        ack(32'hCAFEBABE);
        check("b2b_second_wbe", bus.wbe_o,  32'd1);
        check("b2b_second_d",   bus.wb_d_o, 32'hCAFEBABE);
        step();
        check("b2b_hazard_off", bus.hazard_o, 32'd0);

        // Request during WAIT is dropped and flags an error
        issue(5'd4, 2'd1, 1'b0, 2'd0);
        issue(5'd9, 2'd2, 1'b0, 2'd0);
        check("err_set", bus.ld_err_o, 32'd1);
        bus.ra_chk_i = 5'd9;
        #1;
        check("err_no_pend", bus.hazard_o, 32'd0);
        ack(32'hA5A51234);
        check("err_wb_addr", bus.wb_addr_o, 32'd4);
        check("err_wb_d",    bus.wb_d_o,    32'h0000A5A5);
        step();
        step();
        check("err_no_extra_wbe", bus.wbe_o,     32'd0);
        check("err_sticky",       bus.ld_err_o,  32'd1);
        check("err_idle",         bus.ld_busy_o, 32'd0);

        // Reset during WAIT discards the load
        bus.ra_chk_i = 5'd6;
        issue(5'd6, 2'd2, 1'b0, 2'd0);
        rst_n = 1'b0;
        #1;
        check("rstw_busy_async", bus.ld_busy_o, 32'd0);
        step();
        rst_n = 1'b1;
        ack(32'h55555555);
        check("rstw_wbe",    bus.wbe_o,     32'd0);
        check("rstw_hazard", bus.hazard_o,  32'd0);
        check("rstw_busy",   bus.ld_busy_o, 32'd0);
        check("rstw_err",    bus.ld_err_o,  32'd0);

        // PR (index 16) long load, offset ignored
        bus.ra_chk_i = 5'd0;
        bus.rb_chk_i = 5'd16;
        bus.chk_en_i = 3'b010;
        issue(5'd16, 2'd2, 1'b1, 2'd1);
        check("pr_hazard_rb", bus.hazard_o, 32'd1);
        bus.dst_chk_i = 5'd16;
        bus.chk_en_i  = 3'b100;
        #1;
        check("pr_hazard_dst", bus.hazard_o, 32'd1);
        bus.chk_en_i  = 3'b001;
        #1;
        check("pr_hazard_ra_only", bus.hazard_o, 32'd0);
        ack(32'h13572468);
        check("pr_addr", bus.wb_addr_o, 32'd16);
        check("pr_d",    bus.wb_d_o,    32'h13572468);
        step();

        // Out-of-range load destination is ignored
        bus.ra_chk_i = 5'd20;
        bus.chk_en_i = 3'b111;
        issue(5'd20, 2'd2, 1'b0, 2'd0);
        check("oor_busy",   bus.ld_busy_o, 32'd0);
        check("oor_err",    bus.ld_err_o,  32'd0);
        check("oor_hazard", bus.hazard_o,  32'd0);
        ack(32'h77777777);
        check("oor_wbe", bus.wbe_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sh2_load_writeback.md
# sh2_load_writeback

Writeback stage feeding the SH-2 register file's two write ports. Port A carries single-cycle execute results, registered on pipeline advance. Port B retires one outstanding memory load: it captures the bus data, then aligns and extends it big-endian. The block also keeps a per-register pending-load scoreboard and drives a decode-stage hazard (stall) signal.

## Interface
Parameters:
- REG_NUM, 17, architectural register slots (R0–R15, PR at index 16); destination addresses ≥ REG_NUM are discarded.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- CE  in  1  pipeline advance enable
- EX_WE  in  1  execute result valid
- EX_ADDR  in  5  execute destination
- EX_D  in  32  execute result
- LD_REQ  in  1  load issued; sampled only when CE=1
- LD_ADDR  in  5  load destination register
- LD_SIZE  in  2  0=byte, 1=word, 2=long, 3=reserved (treated as long)
- LD_SIGNED  in  1  sign-extend (0 = zero-extend)
- LD_OFFS  in  2  byte offset of the access within the longword
- BUS_ACK  in  1  load data valid, one-cycle pulse
- BUS_D  in  32  bus read data, big-endian longword
- RA_CHK, RB_CHK, DST_CHK  in  5 each  decode source and destination addresses
- CHK_EN  in  3  enable for the RA, RB and DST checks (bits 0, 1, 2)
- WA_ADDR, WB_ADDR  out  5  register file write addresses
- WA_D, WB_D  out  32  register file write data
- WAE, WBE  out  1  register file write enables
- HAZARD  out  1  decode must stall
- LD_BUSY  out  1  load slot occupied
- LD_ERR  out  1  sticky: LD_REQ arrived while the slot was busy

## Operation
- Port A:
  - On CE: WA_ADDR<=EX_ADDR, WA_D<=EX_D, WAE<=EX_WE & (EX_ADDR<REG_NUM).
  - When CE=0, WAE holds its value. The register file writes port A only when CE=1.
- Load FSM states: IDLE, WAIT, READY.
- IDLE:
  - CE & LD_REQ & LD_ADDR<REG_NUM → capture destination, size, sign and offset.
  - Set pend[LD_ADDR], go to WAIT.
  - If LD_ADDR ≥ REG_NUM the request is ignored.
- WAIT:
  - On BUS_ACK: WB_D<=extracted value, WB_ADDR<=captured destination, WBE<=1, go to READY.
- READY:
  - WBE is held at 1 until a CE cycle. In that cycle the register file samples port B.
  - Next cycle: WBE<=0 and pend cleared, unless the same CE cycle accepts a new LD_REQ.
  - Back-to-back case: a new LD_REQ accepted in the retire CE cycle captures immediately, sets its pend bit (the same bit may stay set) and goes to WAIT.
- LD_BUSY = (state≠IDLE) and not (state=READY & CE).
- LD_REQ with CE while LD_BUSY=1:
  - The request is dropped and LD_ERR is set.
  - LD_ERR clears only on reset.
- Extraction, big-endian:
  - Byte: BUS_D[31-8*OFFS -: 8].
  - Word: OFFS[1]=0 → BUS_D[31:16], else BUS_D[15:0]; OFFS[0] is ignored.
  - Long: BUS_D.
  - Extend to 32 bits by LD_SIGNED.
- HAZARD, combinational:
  - HAZARD = OR over k of (CHK_EN[k] & pend[addr_k]), with addr_k = RA_CHK, RB_CHK, DST_CHK.
  - Addresses ≥ REG_NUM never hit.
  - The DST check prevents an execute write from being overwritten by an older load retiring later.
- Simultaneous events:
  - A port A write and a port B retire to the same register in the same CE cycle: port B lands last. Decode prevents this case via the DST check.
  - BUS_ACK in IDLE or READY is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, pend all 0, LD_ERR 0.
- Reset asserted mid-load discards the load. No WBE is issued after reset.
- Port A latency: 1 CE cycle from EX_* to WAE.
- Port B latency: BUS_ACK at cycle t → WBE=1 at t+1.
- HAZARD:
  - Rises in the cycle after LD_REQ acceptance.
  - Falls in the cycle after the retiring CE.
- With CE=1 continuously and BUS_ACK in the cycle after acceptance, a load occupies the slot for 3 cycles.

## Test plan
- Execute write, CE=1: EX_ADDR=5, EX_D=0xDEADBEEF → next cycle WAE=1, WA_ADDR=5, WA_D=0xDEADBEEF.
- Load byte, signed, OFFS=2, BUS_D=0x1122F344 → WB_D=0xFFFFFFF3, WB_ADDR=LD_ADDR. Repeat unsigned → 0x000000F3.
- Load word, OFFS=2, signed, BUS_D=0x12348001 → WB_D=0xFFFF8001. With CE=0 held 4 cycles, WBE stays 1 and HAZARD stays 1 on RA_CHK=dest.
- Back-to-back: second LD_REQ in the retire CE cycle → no LD_ERR, second load completes. LD_REQ during WAIT → LD_ERR=1 and no extra write.
- RST_N low during WAIT, then BUS_ACK → no WBE, HAZARD=0, LD_BUSY=0.
- LD_ADDR=16 (PR) long load → WB_ADDR=16. LD_ADDR=20 → ignored, LD_BUSY stays 0.
